// File: rtl/mst_fifo_arbiter.sv
// mst_fifo_arbiter: shares one 18-bit master FIFO write port between two
// packet sources. Round-robin grant at packet granularity, with a 1-cycle
// registered write path, stray-word dropping and length-overrun protection.
// Optional statistics counters are enabled with the macro MST_ARB_STATS_EN.
module mst_fifo_arbiter #(
  parameter int unsigned MAX_WORDS = 40
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [17:0] rq0_din,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [17:0] rq1_din,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  output logic [17:0] mst_din,
  output logic        mst_wr_en,
  input  logic        mst_afull,
  output logic [1:0]  grant,
  output logic [1:0]  err_flags,
  input  logic        err_clr
`ifdef MST_ARB_STATS_EN
  ,
  output logic [15:0] rq0_pkt_cnt,
  output logic [15:0] rq1_pkt_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [7:0] LAST_CNT = 8'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  arb_state_t  state, state_nxt;
  logic        rr_last, rr_last_nxt;
  logic [7:0]  word_cnt, word_cnt_nxt;
  logic        elig0, elig1;
  logic        rdy0, rdy1;
  logic        own_valid;
  logic [17:0] own_din;
  logic        acc_valid;
  logic [17:0] acc_word;
  logic        stray_drop, overrun;

  assign elig0 = rq0_valid & rq0_din[17];
  assign elig1 = rq1_valid & rq1_din[17];

  // Ready is held low while reset is asserted so all outputs read zero.
  assign rq0_ready = rdy0 & sys_rst_n;
  assign rq1_ready = rdy1 & sys_rst_n;

  // Next-state, arbitration, ready generation and word acceptance.
  always_comb begin
    state_nxt    = state;
    rr_last_nxt  = rr_last;
    word_cnt_nxt = word_cnt;
    rdy0         = 1'b0;
    rdy1         = 1'b0;
    own_valid    = 1'b0;
    own_din      = 18'd0;
    stray_drop   = 1'b0;
    overrun      = 1'b0;
    acc_valid    = 1'b0;
    acc_word     = 18'd0;
    grant        = 2'b00;
    case (state)
      ARB_IDLE: begin
        // A granted requester always shows a command word, so it is never a stray.
        rdy0       = rq0_valid & ~rq0_din[17];
        rdy1       = rq1_valid & ~rq1_din[17];
        stray_drop = rdy0 | rdy1;
        if (elig0 && (!elig1 || rr_last)) begin
          state_nxt    = ARB_GNT0;
          rr_last_nxt  = 1'b0;
          word_cnt_nxt = 8'd0;
        end else if (elig1) begin
          state_nxt    = ARB_GNT1;
          rr_last_nxt  = 1'b1;
          word_cnt_nxt = 8'd0;
        end else begin
          state_nxt = ARB_IDLE;
        end
      end
      ARB_GNT0: begin
        grant     = 2'b01;
        rdy0      = ~mst_afull;
        own_valid = rq0_valid;
        own_din   = rq0_din;
      end
      ARB_GNT1: begin
        grant     = 2'b10;
        rdy1      = ~mst_afull;
        own_valid = rq1_valid;
        own_din   = rq1_din;
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase

    if (own_valid && !mst_afull) begin
      acc_valid    = 1'b1;
      acc_word     = own_din;
      word_cnt_nxt = word_cnt + 8'd1;
      if (own_din[16]) begin
        state_nxt = ARB_IDLE;
      end else if (word_cnt == LAST_CNT) begin
        overrun   = 1'b1;
        state_nxt = ARB_IDLE;
      end else begin
        state_nxt = state;
      end
    end else begin
      acc_valid = 1'b0;
    end
  end

  // Arbiter state, round-robin pointer and packet word counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ARB_IDLE;
      rr_last  <= 1'b1;
      word_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      rr_last  <= rr_last_nxt;
      word_cnt <= word_cnt_nxt;
    end
  end

  // Registered master FIFO write port; data holds when nothing is written.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mst_din   <= 18'd0;
      mst_wr_en <= 1'b0;
    end else begin
      mst_wr_en <= acc_valid;
      if (acc_valid) begin
        mst_din <= acc_word;
      end else begin
        mst_din <= mst_din;
      end
    end
  end

  // Sticky error flags; a set event in the same cycle beats the clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_flags <= 2'b00;
    end else begin
      err_flags <= (err_clr ? 2'b00 : err_flags) | {overrun, stray_drop};
    end
  end

`ifdef MST_ARB_STATS_EN
  logic pkt_end0, pkt_end1, stall;

  assign pkt_end0 = acc_valid & acc_word[16] & (state == ARB_GNT0);
  assign pkt_end1 = acc_valid & acc_word[16] & (state == ARB_GNT1);
  assign stall    = (state != ARB_IDLE) & own_valid & mst_afull;

  // Wrapping completed-packet and backpressure-stall counters.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rq0_pkt_cnt <= 16'd0;
      rq1_pkt_cnt <= 16'd0;
      stall_cnt   <= 16'd0;
    end else begin
      rq0_pkt_cnt <= pkt_end0 ? rq0_pkt_cnt + 16'd1 : rq0_pkt_cnt;
      rq1_pkt_cnt <= pkt_end1 ? rq1_pkt_cnt + 16'd1 : rq1_pkt_cnt;
      stall_cnt   <= stall    ? stall_cnt + 16'd1   : stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mst_fifo_arbiter.sv
// Scoreboard bench for mst_fifo_arbiter: tests queue hand-computed expected
// master FIFO words; an independent monitor pops and compares on each write.
module tb_mst_fifo_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [17:0] rq0_din, rq1_din;
  logic        rq0_valid, rq1_valid;
  logic        rq0_ready, rq1_ready;
  logic [17:0] mst_din;
  logic        mst_wr_en;
  logic        mst_afull;
  logic [1:0]  grant;
  logic [1:0]  err_flags;
  logic        err_clr;
`ifdef MST_ARB_STATS_EN
  logic [15:0] rq0_pkt_cnt, rq1_pkt_cnt, stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  int base;
  logic [17:0] exp_q[$];
  logic [17:0] src0_q[$];
  logic [17:0] src1_q[$];
  logic [17:0] exp_w;

  always #5 sys_clk = ~sys_clk;

  mst_fifo_arbiter #(.MAX_WORDS(40)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rq0_din   (rq0_din),
    .rq0_valid (rq0_valid),
    .rq0_ready (rq0_ready),
    .rq1_din   (rq1_din),
    .rq1_valid (rq1_valid),
    .rq1_ready (rq1_ready),
    .mst_din   (mst_din),
    .mst_wr_en (mst_wr_en),
    .mst_afull (mst_afull),
    .grant     (grant),
    .err_flags (err_flags),
    .err_clr   (err_clr)
`ifdef MST_ARB_STATS_EN
    ,
    .rq0_pkt_cnt (rq0_pkt_cnt),
    .rq1_pkt_cnt (rq1_pkt_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every master write must match the head of the expected queue.
  always @(negedge sys_clk) begin
    if (sys_rst_n && mst_wr_en) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=0x%0h required=no_write", mst_din);
      end else begin
        exp_w = exp_q.pop_front();
        if (mst_din !== exp_w) begin
          failures++;
          $display("FAIL write_data actual=0x%0h required=0x%0h", mst_din, exp_w);
        end
      end
    end
  end

  task automatic drive();
    rq0_valid = (src0_q.size() != 0);
    rq0_din   = rq0_valid ? src0_q[0] : 18'd0;
    rq1_valid = (src1_q.size() != 0);
    rq1_din   = rq1_valid ? src1_q[0] : 18'd0;
  endtask

  // One clock: sample handshakes mid-cycle, then advance sources after the edge.
  task automatic step();
    logic a0, a1;
    @(negedge sys_clk);
    a0 = rq0_valid & rq0_ready;
    a1 = rq1_valid & rq1_ready;
    @(posedge sys_clk);
    #1;
    if (a0 && src0_q.size() != 0) void'(src0_q.pop_front());
    if (a1 && src1_q.size() != 0) void'(src1_q.pop_front());
    drive();
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while ((src0_q.size() != 0 || src1_q.size() != 0 || exp_q.size() != 0) && n < bound) begin
      step();
      n++;
    end
    check(name, 32'(n < bound), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mst_din"},   32'(mst_din),   32'd0);
    check({tag, "_wr_en"},     32'(mst_wr_en), 32'd0);
    check({tag, "_grant"},     32'(grant),     32'd0);
    check({tag, "_err_flags"}, 32'(err_flags), 32'd0);
    check({tag, "_rq0_ready"}, 32'(rq0_ready), 32'd0);
    check({tag, "_rq1_ready"}, 32'(rq1_ready), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    #1;
    sys_rst_n = 1'b0;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    drive();
    #1;
    check_all_zero(tag);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    mst_afull = 1'b0;
    err_clr   = 1'b0;
    drive();
    @(posedge sys_clk);
    do_reset("reset0");

    // Single packet from requester 0
    src0_q = '{18'h290FF, 18'h01234, 18'h15678};
    exp_q  = '{18'h290FF, 18'h01234, 18'h15678};
    drive();
    check("single_grant_idle", 32'(grant), 32'd0);
    step();
    check("single_grant_gnt0", 32'(grant), 32'd1);
    step();
    check("single_wr1", 32'(mst_wr_en), 32'd1);
    step();
    check("single_wr2", 32'(mst_wr_en), 32'd1);
    step();
    check("single_wr3", 32'(mst_wr_en), 32'd1);
    check("single_grant_back_idle", 32'(grant), 32'd0);
    step();
    check("single_wr_off", 32'(mst_wr_en), 32'd0);
    check("single_drained", 32'(exp_q.size()), 32'd0);

    // Round-robin from reset: rq0, rq1, rq0
    @(posedge sys_clk);
    do_reset("reset_rr");
    src0_q = '{18'h20001, 18'h00011, 18'h00012, 18'h10013,
               18'h20003, 18'h00031, 18'h00032, 18'h10033};
    src1_q = '{18'h20002, 18'h00021, 18'h00022, 18'h10023};
    exp_q  = '{18'h20001, 18'h00011, 18'h00012, 18'h10013,
               18'h20002, 18'h00021, 18'h00022, 18'h10023,
               18'h20003, 18'h00031, 18'h00032, 18'h10033};
    drive();
    step();
    check("rr_first_grant", 32'(grant), 32'd1);
    drain("rr_drain", 100);
    check("rr_err_flags", 32'(err_flags), 32'd0);
`ifdef MST_ARB_STATS_EN
    check("rr_rq0_pkt_cnt", 32'(rq0_pkt_cnt), 32'd2);
    check("rr_rq1_pkt_cnt", 32'(rq1_pkt_cnt), 32'd1);
`endif

    // Backpressure: five stalled cycles mid-packet
    src0_q = '{18'h20004, 18'h00041, 18'h00042, 18'h00043, 18'h00044, 18'h10045};
    exp_q  = '{18'h20004, 18'h00041, 18'h00042, 18'h00043, 18'h00044, 18'h10045};
    drive();
    step();
    step();
    step();
    mst_afull = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_low", 32'(rq0_ready), 32'd0);
      step();
      check("bp_wr_en_low", 32'(mst_wr_en), 32'd0);
    end
    mst_afull = 1'b0;
    drain("bp_drain", 50);
`ifdef MST_ARB_STATS_EN
    check("bp_stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // Stray word from requester 1 in idle, then clear
    check("stray_err_before", 32'(err_flags), 32'd0);
    src1_q = '{18'h00ABC};
    drive();
    step();
    check("stray_err_set", 32'(err_flags), 32'd1);
    check("stray_consumed", 32'(src1_q.size()), 32'd0);
    step();
    check("stray_no_write", 32'(mst_wr_en), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("stray_err_clr", 32'(err_flags), 32'd0);

    // Overrun: command plus 45 words without an end flag
    base = wr_count;
    src0_q.push_back(18'h20100);
    exp_q.push_back(18'h20100);
    for (int i = 1; i <= 45; i++) begin
      src0_q.push_back(18'(i));
      if (i <= 39) exp_q.push_back(18'(i));
    end
    drive();
    drain("ovr_drain", 300);
    check("ovr_words_written", 32'(wr_count - base), 32'd40);
    check("ovr_err_flags", 32'(err_flags), 32'd3);
    check("ovr_grant_idle", 32'(grant), 32'd0);

    // Reset in the middle of a packet, then a fresh packet
    src0_q = '{18'h20005, 18'h00051, 18'h00052, 18'h10053};
    exp_q  = '{18'h20005};
    drive();
    step();
    step();
    step();
    check("mid_wr_before_reset", 32'(mst_wr_en), 32'd1);
    do_reset("reset_mid");
    src0_q = '{18'h20006, 18'h00061, 18'h10062};
    exp_q  = '{18'h20006, 18'h00061, 18'h10062};
    drive();
    step();
    check("post_reset_grant", 32'(grant), 32'd1);
    drain("post_reset_drain", 50);
    step();
    check("post_reset_idle", 32'(grant), 32'd0);
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
